uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter that drains bytes from the TX FIFO and serialises them onto `txLine`, using the same 16× baud tick and line-control register format as the UART receive path. It sits between the TX FIFO and the UART pad. It supports 5–8 data bits, optional normal or stick parity, and 1 or 2 stop bits. Every frame it sends is accepted without error by our receiver when both sides use the same `controlReg`.

## Interface
- No parameters.
- `clock` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `baudRateX16Tick` input 1: one-cycle strobe at 16× the baud rate.
- `controlReg` input 6: line control.
  - [1:0] word length: 0→5, 1→6, 2→7, 3→8 bits.
  - [2] two stop bits.
  - [3] parity enable.
  - [4] even-parity select.
  - [5] computed parity (1) or stick parity (0).
- `fifoEmpty` input 1: TX FIFO empty.
- `fifoData` input 8: FIFO head word. The FIFO is first-word-fall-through: data is valid whenever `fifoEmpty`=0.
- `sendBreak` input 1: force line low. Honoured only with `UART_TX_BREAK_EN`; the port is always present.
- `fifoRe` output 1: one-cycle pop strobe.
- `txLine` output 1: serial output, idle high.
- `busy` output 1: high while a frame is in progress.

## Operation
- **States:** IDLE, LOAD, SEND.
- **IDLE:**
  - `txLine`=1.
  - Moves to LOAD in the cycle after `fifoEmpty`=0 is seen.
- **LOAD (exactly one cycle):**
  - `fifoRe`=1.
  - `controlReg` and `fifoData` are latched.
  - The frame is built into a 12-bit shift register, LSB first: start 0, N data bits LSB first, optional parity, 1 or 2 stop bits of 1.
  - Bit count loaded = 1+N+P+S, range 7..12.
  - Baud counter cleared.
- **Parity bit:**
  - `controlReg[5]`=1: parity = XOR(data) when `controlReg[4]`=1 (even); ~XOR(data) when `controlReg[4]`=0 (odd).
  - `controlReg[5]`=0 (stick parity): parity = ~`controlReg[4]`.
- **SEND:**
  - `txLine` = shift register bit 0.
  - Each `baudRateX16Tick` increments the 4-bit baud counter.
  - On a tick with counter=15: counter wraps to 0, the shift register shifts right filling 1, and the bit count decrements.
  - When the bit count reaches 0: go to IDLE. If `fifoEmpty`=0 at that point, IDLE goes straight to LOAD next cycle (back-to-back frames).
- **Mid-frame changes:** `controlReg` changes during SEND have no effect on the current frame. Neither do `fifoEmpty` or `fifoData` changes.
- **`busy`:** equals state≠IDLE.
- **`reset`:**
  - Any state, including mid-frame → IDLE next cycle.
  - Outputs: `txLine`=1, `fifoRe`=0, `busy`=0; counters cleared.
  - The interrupted frame is not resumed, and no FIFO pop occurs.

## Timing
- All outputs are registered except `fifoRe`, which is decoded from state==LOAD.
- Latency:
  - `fifoEmpty` falls at cycle t → `fifoRe` at t+1.
  - Start bit appears on `txLine` at t+2.
- Bit length: 16 `baudRateX16Tick` strobes per bit. The start bit may run up to one tick-period longer, because SEND starts asynchronously to the tick.
- Frame length (8N1): 160 ticks.
- Inter-frame gap with a non-empty FIFO: ≤2 clock cycles of idle-high after the last stop bit.
- `fifoRe` is never asserted while `fifoEmpty`=1, and never twice per frame.

## Configuration
- Macro: `UART_TX_BREAK_EN`.
- **Defined:**
  - While `sendBreak`=1, `txLine` is forced to 0 from the next cycle.
  - The frame engine keeps running underneath, so the FIFO keeps draining. Data sent during a break is lost, which matches 16550 behaviour.
  - Releasing `sendBreak` restores normal `txLine` on the next cycle.
- **Undefined:** `sendBreak` is ignored; no break logic is synthesised.

## Structure
- **Shared UART package:**
  - State encodings IDLE/LOAD/SEND.
  - Word-length codes.
  - `controlReg` bit-position constants: WLEN, STOP2, PEN, EPS, SPAR. The receive path uses the same constants.
- **Sub-module `uart_tx_frame_builder`** (combinational): takes data plus `controlReg`, produces the 12-bit frame vector and the 4-bit bit count.

## Test plan
- **8N1 (`controlReg`=6'b000011), push 0x55:**
  - One `fifoRe` pulse.
  - `txLine` = 0,1,0,1,0,1,0,1,0,1, each bit 16 ticks.
  - Idle high after 160 ticks; `busy` low.
- **7E1 (6'b111010), 0x41:**
  - Data 1000001 LSB first, then parity 0, then stop 1.
  - Our receiver, looped back, reports `parityError`=0 and data 0x41.
- **5-bit with 2 stop bits (6'b000100), 0x1F:** frame 0,1,1,1,1,1,1,1, total 128 ticks.
- **Stick parity (6'b001011), 0x00:** parity bit = 1. With 6'b011011, parity bit = 0.
- **Back-to-back and reset:**
  - 3 words queued → 3 frames, ≤2 idle cycles between them, 3 `fifoRe` pulses.
  - Assert `reset` mid-data-bit → `txLine`=1 next cycle, no further `fifoRe`.
- **`UART_TX_BREAK_EN`:**
  - `sendBreak` held for 200 ticks → `txLine`=0 throughout.
  - Our receiver reports `breakDetected`=1.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART package: FSM encodings, word-length codes and
// line-control bit positions used by both TX and RX paths.
package uart_tx_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    localparam logic [1:0] WLEN_5 = 2'd0;
    localparam logic [1:0] WLEN_6 = 2'd1;
    localparam logic [1:0] WLEN_7 = 2'd2;
    localparam logic [1:0] WLEN_8 = 2'd3;

    localparam int CTRL_WLEN_LO = 0;
    localparam int CTRL_WLEN_HI = 1;
    localparam int CTRL_STOP2   = 2;
    localparam int CTRL_PEN     = 3;
    localparam int CTRL_EPS     = 4;
    localparam int CTRL_SPAR    = 5;

    // Number of data bits for a word-length code.
    function automatic logic [3:0] wlen_bits(input logic [1:0] code);
        logic [3:0] n;
        case (code)
            WLEN_5:  n = 4'd5;
            WLEN_6:  n = 4'd6;
            WLEN_7:  n = 4'd7;
            WLEN_8:  n = 4'd8;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/uart_tx_frame_builder.sv
// Combinational frame assembly: start, data LSB first,
// optional parity, 1 or 2 stop bits, plus total bit count.
module uart_tx_frame_builder
    import uart_tx_pkg::*;
(
    input  logic [7:0]  data,
    input  logic [5:0]  ctrl,
    output logic [11:0] frame,
    output logic [3:0]  bit_cnt
);

    logic [3:0]  n_bits;
    logic [7:0]  data_m;
    logic        par;
    logic [10:0] body;

    // Data bits above the word length are replaced by ones, so
    // stop bits fall out of the fill; parity overwrites bit N.
    always_comb begin
        n_bits = wlen_bits(ctrl[CTRL_WLEN_HI:CTRL_WLEN_LO]);
        data_m = data & ~(8'hFF << n_bits);
        if (ctrl[CTRL_SPAR]) begin
            par = ctrl[CTRL_EPS] ? (^data_m) : ~(^data_m);
        end else begin
            par = ~ctrl[CTRL_EPS];
        end
        body = {3'b000, data_m} | (11'h7FF << n_bits);
        if (ctrl[CTRL_PEN]) begin
            body = (body & ~(11'h001 << n_bits))
                 | ({10'd0, par} << n_bits);
        end
        frame   = {body, 1'b0};
        bit_cnt = 4'd2 + n_bits
                + {3'd0, ctrl[CTRL_PEN]}
                + {3'd0, ctrl[CTRL_STOP2]};
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops the FWFT TX FIFO and shifts frames out
// at 16 ticks per bit. Optional break via `UART_TX_BREAK_EN.
module uart_tx
    import uart_tx_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       baudRateX16Tick,
    input  logic [5:0] controlReg,
    input  logic       fifoEmpty,
    input  logic [7:0] fifoData,
    input  logic       sendBreak,
    output logic       fifoRe,
    output logic       txLine,
    output logic       busy
);

    logic [1:0]  state_q,  state_d;
    logic [11:0] shift_q,  shift_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [3:0]  baud_q,   baud_d;
    logic        tx_q,     tx_d;
    logic        busy_q,   busy_d;
    logic        line_d;

    logic [11:0] frame;
    logic [3:0]  frame_cnt;

    uart_tx_frame_builder u_builder (
        .data    (fifoData),
        .ctrl    (controlReg),
        .frame   (frame),
        .bit_cnt (frame_cnt)
    );

    // Frame engine: controls and data are only looked at in LOAD.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        baud_d   = baud_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifoEmpty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d  = frame;
                bitcnt_d = frame_cnt;
                baud_d   = 4'd0;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (baudRateX16Tick) begin
                    baud_d = baud_q + 4'd1;
                    if (baud_q == 4'd15) begin
                        shift_d  = {1'b1, shift_q[11:1]};
                        bitcnt_d = bitcnt_q - 4'd1;
                        if (bitcnt_q == 4'd1) state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line value follows the next state so txLine is registered.
    always_comb begin
        line_d = (state_d == ST_SEND) ? shift_d[0] : 1'b1;
        busy_d = (state_d != ST_IDLE);
`ifdef UART_TX_BREAK_EN
        tx_d   = line_d & ~sendBreak;
`else
        tx_d   = line_d;
`endif
    end

`ifndef UART_TX_BREAK_EN
    logic unused_break;
    assign unused_break = sendBreak;
`endif

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '1;
            bitcnt_q <= 4'd0;
            baud_q   <= 4'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            baud_q   <= baud_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    assign fifoRe = (state_q == ST_LOAD);
    assign txLine = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: FWFT FIFO model, tick
// generator and a bit-list frame reference model.
module tb_uart_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       baudRateX16Tick;
    logic [5:0] controlReg;
    logic       fifoEmpty;
    logic [7:0] fifoData;
    logic       sendBreak;
    logic       fifoRe;
    logic       txLine;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int pushes = 0;

    logic [7:0] fifo_q[$];
    bit         pop_pend = 1'b0;
    bit         exp_q[$];

    uart_tx dut (
        .clock           (clock),
        .reset           (reset),
        .baudRateX16Tick (baudRateX16Tick),
        .controlReg      (controlReg),
        .fifoEmpty       (fifoEmpty),
        .fifoData        (fifoData),
        .sendBreak       (sendBreak),
        .fifoRe          (fifoRe),
        .txLine          (txLine),
        .busy            (busy)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tick every 4 clocks; FIFO pops take effect at the clock edge.
    initial begin
        int div;
        div = 0;
        baudRateX16Tick = 1'b0;
        fifoEmpty = 1'b1;
        fifoData = 8'h00;
        forever begin
            @(posedge clock);
            #1;
            div = (div + 1) % 4;
            baudRateX16Tick = (div == 0);
            if (pop_pend && fifo_q.size() > 0) fifo_q.delete(0);
            fifoEmpty = (fifo_q.size() == 0);
            fifoData = fifoEmpty ? 8'($urandom) : fifo_q[0];
        end
    end

    initial forever begin
        @(negedge clock);
        pop_pend = (fifoRe === 1'b1);
        if (fifoRe === 1'b1) begin
            pops++;
            chk("pop_nonempty", {31'd0, fifoEmpty}, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: expected line bits of one frame, start first.
    task automatic build_exp(input logic [5:0] c, input logic [7:0] d,
                             output int n);
        int nd;
        int ones;
        bit b;
        bit p;
        nd = 5 + int'(c[1:0]);
        ones = 0;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            b = ((d >> i) & 8'd1) != 8'd0;
            ones += int'(b);
            exp_q.push_back(b);
        end
        if (c[3]) begin
            if (c[5]) p = c[4] ? (ones % 2 == 1) : (ones % 2 == 0);
            else p = !c[4];
            exp_q.push_back(p);
        end
        exp_q.push_back(1'b1);
        if (c[2]) exp_q.push_back(1'b1);
        n = exp_q.size();
    endtask

    task automatic push_word(input logic [7:0] d);
        @(posedge clock);
        #2;
        fifo_q.push_back(d);
        pushes++;
    endtask

    // Waits for the pop, then samples txLine on every tick.
    task automatic check_frame(input logic [5:0] c, input logic [7:0] d,
                               input int max_wait, input bit exact,
                               input bit scramble);
        int n;
        int w;
        int k;
        int cyc;
        logic [15:0] sv;
        build_exp(c, d, n);
        w = 0;
        do begin
            @(negedge clock);
            w++;
        end while (fifoRe !== 1'b1 && w < 40);
        chk("pop_seen", {31'd0, fifoRe}, 32'd1);
        if (exact) chk("pop_latency", w, max_wait);
        else chk("pop_gap", {31'd0, w <= max_wait}, 32'd1);
        k = 0;
        cyc = 0;
        sv = '0;
        while (k < 16 * n && cyc < 64 * n + 16) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) begin
                chk("start_bit", {31'd0, txLine}, 32'd0);
                chk("busy_send", {31'd0, busy}, 32'd1);
            end
            if (baudRateX16Tick) begin
                sv = {sv[14:0], txLine};
                k++;
                if (k % 16 == 0)
                    chk($sformatf("bit%0d", k / 16 - 1), {16'd0, sv},
                        {16'd0, {16{exp_q[k / 16 - 1]}}});
            end
            if (scramble && cyc > 1) begin
                controlReg = 6'($urandom);
`ifndef UART_TX_BREAK_EN
                sendBreak = 1'($urandom);
`endif
            end
        end
        sendBreak = 1'b0;
        chk("frame_ticks", k, 16 * n);
        @(negedge clock);
        chk("idle_line", {31'd0, txLine}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [5:0] c;
        logic [7:0] d;
        logic [7:0] words[3];
        int p0;
        int highs;
        int w;
        reset = 1'b1;
        controlReg = 6'b000011;
        sendBreak = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_line", {31'd0, txLine}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pop", {31'd0, fifoRe}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Queued at cycle t-1, FIFO non-empty at t, pop at t+1.
        controlReg = 6'b000011;
        push_word(8'h55);
        check_frame(6'b000011, 8'h55, 3, 1'b1, 1'b0);
        controlReg = 6'b111010;
        push_word(8'h41);
        check_frame(6'b111010, 8'h41, 3, 1'b1, 1'b0);
        controlReg = 6'b000100;
        push_word(8'h1F);
        check_frame(6'b000100, 8'h1F, 3, 1'b1, 1'b0);
        controlReg = 6'b001011;
        push_word(8'h00);
        check_frame(6'b001011, 8'h00, 3, 1'b1, 1'b0);
        controlReg = 6'b011011;
        push_word(8'h00);
        check_frame(6'b011011, 8'h00, 3, 1'b1, 1'b0);

        repeat (12) begin
            c = 6'($urandom);
            d = 8'($urandom);
            controlReg = c;
            push_word(d);
            check_frame(c, d, 3, 1'b1, 1'b1);
        end

        c = 6'($urandom);
        controlReg = c;
        for (int i = 0; i < 3; i++) begin
            words[i] = 8'($urandom);
            push_word(words[i]);
        end
        check_frame(c, words[0], 3, 1'b0, 1'b0);
        check_frame(c, words[1], 2, 1'b0, 1'b0);
        check_frame(c, words[2], 2, 1'b0, 1'b0);
        chk("b2b_pops", pops, pushes);

        controlReg = 6'b000011;
        push_word(8'h00);
        w = 0;
        do begin
            @(negedge clock);
            w++;
        end while (fifoRe !== 1'b1 && w < 40);
        chk("rst_pop_seen", {31'd0, fifoRe}, 32'd1);
        w = 0;
        while (w < 40) begin
            @(negedge clock);
            if (baudRateX16Tick) w++;
        end
        chk("mid_data", {31'd0, txLine}, 32'd0);
        p0 = pops;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_line", {31'd0, txLine}, 32'd1);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        highs = 0;
        repeat (200) begin
            @(negedge clock);
            if (txLine === 1'b1) highs++;
        end
        chk("rst_stays_idle", highs, 200);
        chk("rst_no_pop", pops, p0);

`ifdef UART_TX_BREAK_EN
        @(posedge clock);
        #1;
        sendBreak = 1'b1;
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h3C);
        pushes += 2;
        @(posedge clock);
        highs = 0;
        repeat (800) begin
            @(negedge clock);
            if (txLine === 1'b0) highs++;
        end
        chk("break_low", highs, 800);
        @(posedge clock);
        #1;
        sendBreak = 1'b0;
        w = 0;
        while ((fifo_q.size() != 0 || busy !== 1'b0) && w < 4000) begin
            @(negedge clock);
            w++;
        end
        @(negedge clock);
        chk("break_drained", {31'd0, busy === 1'b0}, 32'd1);
        chk("break_release", {31'd0, txLine}, 32'd1);
`endif

        chk("pop_total", pops, pushes);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
